// File: rtl/seed_loader.sv
// seed_loader: assembles a ROWSxCOLS Life seed from a valid/ready row stream,
// commits it with a one-cycle pulse and drives CONTROL's run switch.
module seed_loader #(
    parameter int ROWS    = 8,
    parameter int COLS    = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic [COLS-1:0]          row_data,
    input  logic                     row_valid,
    output logic                     row_ready,
    output logic [ROWS*COLS-1:0]     seed,
    output logic                     seed_valid,
    output logic                     run,
    output logic                     busy,
    output logic [$clog2(ROWS):0]    row_count,
    output logic                     error
);
    localparam int RW = $clog2(ROWS) + 1;
    localparam int IW = $clog2(ROWS);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t               state;
    logic [ROWS*COLS-1:0] shadow;
    logic [TW-1:0]        idle_cnt;
    logic [IW-1:0]        row_idx;
    logic                 accept;

    assign busy      = state == LOAD;
    assign row_ready = busy;
    assign accept    = row_valid & row_ready;
    assign row_idx   = row_count[IW-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            seed       <= '0;
            shadow     <= '0;
            seed_valid <= 1'b0;
            run        <= 1'b0;
            row_count  <= '0;
            error      <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            seed_valid <= 1'b0;
            case (state)
                IDLE: if (start && !stop) begin
                    state     <= LOAD;
                    row_count <= '0;
                    shadow    <= '0;
                    idle_cnt  <= '0;
                    error     <= 1'b0;
                end
                LOAD: if (stop) begin
                    state <= IDLE;
                end else if (start) begin
                    row_count <= '0;
                    shadow    <= '0;
                    idle_cnt  <= '0;
                end else if (accept) begin
                    shadow[row_idx*COLS +: COLS] <= row_data;
                    row_count <= row_count + 1'b1;
                    idle_cnt  <= '0;
                    if (row_count == RW'(ROWS - 1)) begin
                        seed       <= {row_data, shadow[(ROWS-1)*COLS-1:0]};
                        seed_valid <= 1'b1;
                        run        <= 1'b1;
                        state      <= RUN;
                    end
                // this idle edge is the one that takes the count to TIMEOUT-1
                end else if (idle_cnt == TW'(TIMEOUT - 2)) begin
                    state <= IDLE;
                    error <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
                RUN: if (stop) begin
                    state <= IDLE;
                    run   <= 1'b0;
                end else if (start) begin
                    state     <= LOAD;
                    run       <= 1'b0;
                    row_count <= '0;
                    shadow    <= '0;
                    idle_cnt  <= '0;
                    error     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seed_loader.sv
// tb_seed_loader: directed test-plan scenarios plus randomized traffic,
// checked cycle by cycle against a queue-based behavioural model.
module tb_seed_loader;
    localparam int ROWS = 8, COLS = 8, TIMEOUT = 16;
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0, row_valid = 1'b0;
    logic [7:0]  row_data = '0;
    logic        row_ready, seed_valid, run, busy, error;
    logic [63:0] seed;
    logic [3:0]  row_count;

    always #5 clk = ~clk;

    seed_loader #(.ROWS(ROWS), .COLS(COLS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
        .seed(seed), .seed_valid(seed_valid), .run(run), .busy(busy),
        .row_count(row_count), .error(error)
    );

    int passed = 0, total = 0, sv_cnt = 0;

    int          m_mode, m_idle;
    logic [7:0]  m_rows[$];
    logic [63:0] m_seed;
    logic        m_sv, m_run, m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_idle = 0; m_rows.delete();
        m_seed = '0; m_sv = 0; m_run = 0; m_err = 0;
    endtask

    task automatic model_step(input logic st, input logic sp, input logic v, input logic [7:0] d);
        m_sv = 0;
        if (m_mode == M_IDLE) begin
            if (st && !sp) begin
                m_mode = M_LOAD; m_rows.delete(); m_idle = 0; m_err = 0;
            end
        end else if (m_mode == M_LOAD) begin
            if (sp) m_mode = M_IDLE;
            else if (st) begin
                m_rows.delete(); m_idle = 0;
            end else if (v) begin
                m_rows.push_back(d);
                m_idle = 0;
                if (m_rows.size() == ROWS) begin
                    for (int r = 0; r < ROWS; r++) m_seed[r*8 +: 8] = m_rows[r];
                    m_sv = 1; m_run = 1; m_mode = M_RUN;
                end
            end else begin
                m_idle++;
                if (m_idle == TIMEOUT - 1) begin
                    m_mode = M_IDLE; m_err = 1;
                end
            end
        end else begin
            if (sp) begin
                m_mode = M_IDLE; m_run = 0;
            end else if (st) begin
                m_mode = M_LOAD; m_run = 0; m_rows.delete(); m_idle = 0; m_err = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("seed", seed, m_seed);
        check("seed_valid", 64'(seed_valid), 64'(m_sv));
        check("run", 64'(run), 64'(m_run));
        check("busy", 64'(busy), 64'(m_mode == M_LOAD));
        check("row_count", 64'(row_count), 64'(m_rows.size()));
        check("error", 64'(error), 64'(m_err));
    endtask

    task automatic cyc(input logic st, input logic sp, input logic v, input logic [7:0] d);
        start = st; stop = sp; row_valid = v; row_data = d;
        #0 check("row_ready", 64'(row_ready), 64'(m_mode == M_LOAD));
        @(posedge clk);
        model_step(st, sp, v, d);
        #1;
        if (seed_valid) sv_cnt++;
        compare_all();
    endtask

    task automatic send(input logic [7:0] d, input int gap);
        cyc(0, 0, 1, d);
        repeat (gap) cyc(0, 0, 0, 8'h00);
    endtask

    task automatic async_reset();
        #2 reset = 1'b0;
        #1;
        check("arst seed", seed, 64'h0);
        check("arst busy", 64'(busy), 64'h0);
        check("arst row_count", 64'(row_count), 64'h0);
        check("arst run", 64'(run), 64'h0);
        check("arst error", 64'(error), 64'h0);
        model_reset();
        #3 reset = 1'b1;
    endtask

    logic [7:0] nom[8] = '{8'h28, 8'h3C, 8'h34, 8'h00, 8'h24, 8'h64, 8'h12, 8'h04};

    initial begin
        model_reset();
        #1;
        check("reset seed", seed, 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        check("reset row_ready", 64'(row_ready), 64'h0);
        check("reset seed_valid", 64'(seed_valid), 64'h0);
        #1 reset = 1'b1;
        cyc(0, 0, 0, 8'h00);

        // nominal back-to-back load
        cyc(1, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) send(nom[i], 0);
        check("nom seed", seed, 64'h0412_6424_0034_3C28);
        check("nom seed_valid", 64'(seed_valid), 64'h1);
        check("nom run", 64'(run), 64'h1);
        check("nom row_count", 64'(row_count), 64'd8);
        check("nom busy", 64'(busy), 64'h0);
        cyc(0, 0, 0, 8'h00);
        check("nom pulse width", 64'(seed_valid), 64'h0);

        // timeout after 3 rows
        sv_cnt = 0;
        cyc(1, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) send(8'hFF, 0);
        repeat (14) cyc(0, 0, 0, 8'h00);
        check("to busy at 14", 64'(busy), 64'h1);
        cyc(0, 0, 0, 8'h00);
        check("to busy at 15", 64'(busy), 64'h0);
        check("to error", 64'(error), 64'h1);
        check("to run", 64'(run), 64'h0);
        check("to seed", seed, 64'h0412_6424_0034_3C28);
        check("to no commit", 64'(sv_cnt), 64'h0);

        // gapped source, then valid pulses in RUN and IDLE
        cyc(1, 0, 0, 8'h00);
        check("gap error cleared", 64'(error), 64'h0);
        for (int i = 0; i < 8; i++) send(nom[i], 3);
        check("gap seed", seed, 64'h0412_6424_0034_3C28);
        check("gap error", 64'(error), 64'h0);
        repeat (3) cyc(0, 0, 1, 8'hAB);
        check("gap run row_count", 64'(row_count), 64'd8);
        cyc(0, 1, 0, 8'h00);
        check("stop run", 64'(run), 64'h0);
        check("stop run seed", seed, 64'h0412_6424_0034_3C28);
        repeat (2) cyc(0, 0, 1, 8'hCD);
        check("idle row_count", 64'(row_count), 64'd8);

        // restart mid-load
        sv_cnt = 0;
        cyc(1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) send(8'hAA, 0);
        cyc(1, 0, 0, 8'h00);
        check("restart row_count", 64'(row_count), 64'h0);
        for (int i = 0; i < 8; i++) send(8'h55, 0);
        check("restart seed", seed, 64'h5555_5555_5555_5555);
        cyc(0, 0, 0, 8'h00);
        check("restart pulses", 64'(sv_cnt), 64'h1);

        // start together with an accept discards that row
        cyc(1, 0, 0, 8'h00);
        send(8'h3C, 0); send(8'h3C, 0);
        cyc(1, 0, 1, 8'h99);
        check("start+accept row_count", 64'(row_count), 64'h0);
        for (int i = 0; i < 8; i++) send(8'h3C, 0);
        check("start+accept seed", seed, 64'h3C3C_3C3C_3C3C_3C3C);

        // stop in LOAD after 4 rows
        sv_cnt = 0;
        cyc(1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) send(8'h77, 0);
        cyc(0, 1, 1, 8'h77);
        check("stop load busy", 64'(busy), 64'h0);
        check("stop load error", 64'(error), 64'h0);
        check("stop load no commit", 64'(sv_cnt), 64'h0);
        check("stop load seed", seed, 64'h3C3C_3C3C_3C3C_3C3C);

        // async reset mid-load, then full load of 0x01
        cyc(1, 0, 0, 8'h00);
        for (int i = 0; i < 6; i++) send(8'hE7, 0);
        async_reset();
        cyc(1, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) send(8'h01, 0);
        check("post-reset seed", seed, 64'h0101_0101_0101_0101);

        // randomized traffic with varying source density
        begin
            int pv = 60;
            for (int i = 0; i < 3000; i++) begin
                if (i % 150 == 0) pv = (i / 150 % 3 == 0) ? 95 : (i / 150 % 3 == 1) ? 60 : 3;
                cyc($urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0,
                    $urandom_range(0, 99) < pv, 8'($urandom));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/seed_loader.md
Name: seed_loader

Overview:
- Input-side counterpart of the 8x8 Life grid dump path: accepts the initial pattern one row at a time over a valid/ready stream.
- Assembles the 64-bit seed and hands it to CONTROL with a one-cycle commit pulse.
- Drives CONTROL's switch (run) input, so evolution starts only after a complete, consistent seed is loaded.
- The previously committed seed is kept intact until a new full load completes.

Parameters:
- ROWS, 8, number of grid rows (rows delivered per load).
- COLS, 8, row width in bits (row_data width).
- TIMEOUT, 16, max idle cycles in LOAD between accepted rows before abort; must be >= 2.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a new load (level sampled each cycle).
- stop  input  1  abort a load / halt run.
- row_data  input  COLS  row pattern; bit c = column c.
- row_valid  input  1  row_data valid.
- row_ready  output  1  loader accepts a row this cycle.
- seed  output  ROWS*COLS  committed grid; row r occupies seed[r*COLS +: COLS].
- seed_valid  output  1  one-cycle commit pulse.
- run  output  1  connects to CONTROL switch.
- busy  output  1  high while in LOAD.
- row_count  output  $clog2(ROWS)+1  rows accepted in the current load.
- error  output  1  sticky timeout flag.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; seed=0, shadow=0; seed_valid=0, run=0, row_ready=0, busy=0, row_count=0, error=0, timeout counter=0.
- Reset is honoured at any time, including mid-load, and discards any partial shadow.
- States: IDLE, LOAD, RUN. All outputs are registered except row_ready and busy, which decode the state (=1 exactly in LOAD).
- Accept event: row_valid & row_ready on a rising edge. row_valid while row_ready=0 is ignored and never buffered.
- IDLE:
  - start=1 & stop=0 -> LOAD; clear row_count, shadow, timeout counter and error.
  - run stays 0.
- LOAD:
  - On accept: shadow[row_count*COLS +: COLS] <= row_data; row_count++; timeout counter <= 0.
  - With no accept: timeout counter++. When the counter reaches TIMEOUT-1 without an accept -> IDLE, error <= 1; seed unchanged.
  - Accept of row ROWS-1: on that edge, seed <= shadow merged with the final row; seed_valid <= 1 for exactly the next cycle; run <= 1; -> RUN.
  - Commit latency = 1 cycle after the last accept. row_count reads ROWS in RUN.
  - stop=1 (priority over accept and start) -> IDLE; no commit, error unchanged.
  - start=1 with stop=0 and no accept that cycle -> restart: row_count, shadow and timeout counter cleared, stay in LOAD.
  - start together with an accept: start wins and the row is discarded, so the source must resend it. Verify this case explicitly.
- RUN:
  - run=1; seed held stable.
  - stop=1 -> IDLE, run <= 0.
  - start=1 & stop=0 -> LOAD, run <= 0 on the same edge; old seed kept until the next commit.
- seed never changes except at commit or reset. seed_valid never asserts for a partial load.
- error is cleared only by reset or by a start that enters LOAD.
- Timeout counter width: $clog2(TIMEOUT); it cannot wrap, because the abort fires at TIMEOUT-1.

Test Plan:
- Nominal load: after reset, start 1 cycle, then rows 0x28,0x3C,0x34,0x00,0x24,0x64,0x12,0x04 on consecutive cycles -> one cycle after the 8th accept: seed=64'h0412_6424_0034_3C28, seed_valid high for exactly 1 cycle, run=1, row_count=8, busy=0.
- Gapped source: same rows with row_valid low for 3 cycles between each row (TIMEOUT=16) -> same seed, no error; row_valid pulses in IDLE/RUN leave row_count unchanged.
- Timeout: load 64'h0412_6424_0034_3C28, start again, send 3 rows of 0xFF, then hold row_valid=0 -> 15 cycles after the last accept: state IDLE, error=1, run=0, seed still 64'h0412_6424_0034_3C28, no seed_valid.
- Restart mid-load: start, 5 rows of 0xAA, pulse start, then 8 rows of 0x55 -> seed=64'h5555_5555_5555_5555; exactly one seed_valid pulse.
- Stop behaviour: stop during LOAD after 4 rows -> IDLE, no commit, error=0. stop in RUN -> run falls on the next edge, seed held.
- Async reset mid-load: drop reset between clock edges after 6 rows -> outputs zero immediately (before the next edge). After release, a full 8-row load of 0x01 gives seed=64'h0101_0101_0101_0101.
